// File: rtl/router_pkt_tx_pkg.sv
// Shared definitions for the router packet source.
//   - Header byte layout: destination in bits [1:0], payload length in bits [7:2].
//   - Legal command limits (illegal destination code, maximum payload length).
//   - Transmit FSM state encoding.
//   - make_header(): packs a length/destination pair into a header byte.
package router_pkt_tx_pkg;

  localparam int MAX_LEN      = 63;
  localparam int LEN_W        = $clog2(MAX_LEN + 1);
  localparam int DEST_W       = 2;

  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 7;

  localparam logic [DEST_W-1:0] ILLEGAL_DEST = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DATA,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY,
    ST_ERR_CHK
  } tx_state_e;

  function automatic logic [7:0] make_header(input logic [LEN_W-1:0]  len,
                                             input logic [DEST_W-1:0] dest);
    logic [7:0] hdr;
    hdr = '0;
    hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
    hdr[HDR_ADDR_MSB:HDR_ADDR_LSB] = dest;
    return hdr;
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Synchronous payload FIFO with occupancy count.
// Ports:
//   clock, resetn  - clock and asynchronous active-low reset (empties the FIFO)
//   push_i         - write push_data_i this cycle
//   push_data_i    - byte to store
//   pop_i          - discard the head entry this cycle
//   head_o         - current head entry (valid while count_o != 0)
//   count_o        - number of stored entries
//   full_o         - count_o == DEPTH
module router_tx_buf #(
  parameter  int DEPTH = 64,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             empty;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem[rd_ptr_q];

  // A push into a full FIFO is still fine when the head leaves the same cycle.
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage array carries no reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q] <= push_data_i;
  end

  // Pointers wrap explicitly so non-power-of-two depths also work.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router input port.
// Accepts a (destination, length) command, waits until the payload buffer
// holds the whole packet, then sends header, payload and parity bytes
// back to back (stalling only on router busy) and reports the router's
// parity-error verdict sampled for ERR_WAIT cycles afterwards.
// Ports:
//   clock, resetn              - clock and asynchronous active-low reset
//   cmd_valid/cmd_ready        - command handshake; cmd_dest, cmd_len fields
//   pl_valid/pl_ready/pl_data  - payload byte stream into the buffer
//   pkt_valid, tx_data         - registered drive of the router input
//   busy, err                  - router flow control and parity error
//   bad_cmd                    - pulse: illegal command dropped
//   tx_done, tx_err            - pulse: packet complete, with err verdict
module router_pkt_tx
  import router_pkt_tx_pkg::*;
#(
  parameter int BUF_DEPTH = 64,
  parameter int ERR_WAIT  = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DEST_W-1:0] cmd_dest,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic [7:0]        pl_data,
  output logic              pkt_valid,
  output logic [7:0]        tx_data,
  input  logic              busy,
  input  logic              err,
  output logic              bad_cmd,
  output logic              tx_done,
  output logic              tx_err
);

  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int WAIT_W = (ERR_WAIT > 0) ? $clog2(ERR_WAIT + 1) : 1;

  tx_state_e          state_q, state_d;
  logic [DEST_W-1:0]  dest_q, dest_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [7:0]         parity_q, parity_d;
  logic               sticky_q, sticky_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               pkt_valid_q, pkt_valid_d;
  logic               bad_cmd_q, bad_cmd_d;
  logic               tx_done_q, tx_done_d;
  logic               tx_err_q, tx_err_d;

  logic               buf_push, buf_pop, buf_full;
  logic [7:0]         buf_head;
  logic [CNT_W-1:0]   buf_count;

  assign pl_ready  = !buf_full;
  assign buf_push  = pl_valid && pl_ready;
  // Gated by resetn so no handshake can be seen while the block is held in reset.
  assign cmd_ready = (state_q == ST_IDLE) && resetn;

  assign pkt_valid = pkt_valid_q;
  assign tx_data   = tx_data_q;
  assign bad_cmd   = bad_cmd_q;
  assign tx_done   = tx_done_q;
  assign tx_err    = tx_err_q;

  router_tx_buf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (8)
  ) u_buf (
    .clock       (clock),
    .resetn      (resetn),
    .push_i      (buf_push),
    .push_data_i (pl_data),
    .pop_i       (buf_pop),
    .head_o      (buf_head),
    .count_o     (buf_count),
    .full_o      (buf_full)
  );

  // Next-state and registered-output logic. A byte on tx_data is consumed
  // at any edge with busy low; otherwise everything holds.
  always_comb begin
    state_d     = state_q;
    dest_d      = dest_q;
    len_d       = len_q;
    remaining_d = remaining_q;
    parity_d    = parity_q;
    sticky_d    = sticky_q;
    wait_d      = wait_q;
    tx_data_d   = tx_data_q;
    pkt_valid_d = pkt_valid_q;
    bad_cmd_d   = 1'b0;
    tx_done_d   = 1'b0;
    tx_err_d    = 1'b0;
    buf_pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_dest == ILLEGAL_DEST || cmd_len == '0) begin
            bad_cmd_d = 1'b1;
          end else begin
            dest_d      = cmd_dest;
            len_d       = cmd_len;
            remaining_d = cmd_len;
            state_d     = ST_WAIT_DATA;
          end
        end
      end
      // Waiting for the full payload keeps pkt_valid gap-free once started.
      ST_WAIT_DATA: begin
        if (buf_count >= CNT_W'(len_q)) begin
          tx_data_d   = make_header(len_q, dest_q);
          parity_d    = make_header(len_q, dest_q);
          pkt_valid_d = 1'b1;
          state_d     = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (!busy) begin
          buf_pop     = 1'b1;
          tx_data_d   = buf_head;
          parity_d    = parity_q ^ buf_head;
          remaining_d = remaining_q - 1'b1;
          state_d     = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (!busy) begin
          if (remaining_q != '0) begin
            buf_pop     = 1'b1;
            tx_data_d   = buf_head;
            parity_d    = parity_q ^ buf_head;
            remaining_d = remaining_q - 1'b1;
          end else begin
            tx_data_d   = parity_q;
            pkt_valid_d = 1'b0;
            state_d     = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (!busy) begin
          tx_data_d = '0;
          sticky_d  = 1'b0;
          wait_d    = WAIT_W'(ERR_WAIT);
          state_d   = ST_ERR_CHK;
        end
      end
      // err is sampled on the ERR_WAIT edges after the parity byte leaves.
      ST_ERR_CHK: begin
        if (wait_q != '0) begin
          sticky_d = sticky_q | err;
          wait_d   = wait_q - 1'b1;
        end else begin
          tx_done_d = 1'b1;
          tx_err_d  = sticky_q;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any packet in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      dest_q      <= '0;
      len_q       <= '0;
      remaining_q <= '0;
      parity_q    <= '0;
      sticky_q    <= 1'b0;
      wait_q      <= '0;
      tx_data_q   <= '0;
      pkt_valid_q <= 1'b0;
      bad_cmd_q   <= 1'b0;
      tx_done_q   <= 1'b0;
      tx_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      dest_q      <= dest_d;
      len_q       <= len_d;
      remaining_q <= remaining_d;
      parity_q    <= parity_d;
      sticky_q    <= sticky_d;
      wait_q      <= wait_d;
      tx_data_q   <= tx_data_d;
      pkt_valid_q <= pkt_valid_d;
      bad_cmd_q   <= bad_cmd_d;
      tx_done_q   <= tx_done_d;
      tx_err_q    <= tx_err_d;
    end
  end

endmodule
